cla_serial_adder: RTL and testbench
===================================

// Module: cla_serial_adder
// PURPOSE
//  Digit-serial add/subtract engine built on the 2-bit propagate/generate + sum slice (pgu_su).
//  Walks a WIDTH-bit operand pair through one pgu_su slice, 2 bits per cycle, LSB first.
//  Drives the slice's a/b/cin/c0 inputs and consumes its p/g/sum outputs.
//  Sits between an operand source (valid/ready) and a result sink (valid/ready).
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be even and >= 2 (else elaboration error)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair a/b/sub is valid
//  in_ready   out  1      engine can accept operands (IDLE only)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      1: compute a-b (b inverted, carry-in 1); 0: a+b
//  out_valid  out  1      sum/cout/ovf valid (DONE only)
//  out_ready  in   1      sink accepts result
//  sum        out  WIDTH  result, mod 2^WIDTH
//  cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      two's-complement overflow
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, sum=0, cout=0, ovf=0, out_valid=0, busy=0, slice index=0, carry=0.
//    Asserting reset mid-RUN or mid-DONE aborts the operation; no partial result is ever flagged valid.
//  - FSM: IDLE -> RUN -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE).
//  - IDLE: on in_valid&in_ready, latch A=a, B=b^{WIDTH{sub}}, carry=sub, idx=0; clear sum; go RUN.
//  - RUN, slice i=idx (bits 2i+1:2i): feed pgu_su a=A[2i+1:2i], b=B[2i+1:2i], cin=carry.
//    Lookahead: c0 = g0 | p0&carry (drives the slice's c0);
//               c1 = g1 | p1&g0 | p1&p0&carry.
//    Each edge: sum[2i+1:2i] <= sout, carry <= c1, idx <= idx+1.
//    Last slice (idx==WIDTH/2-1): cout <= c1, ovf <= c0^c1, go DONE.
//  - Latency: exactly WIDTH/2 clock edges from the accepting edge to out_valid=1 (WIDTH=8: 4).
//  - DONE: sum/cout/ovf held stable while out_valid&!out_ready; in_valid ignored.
//    On out_valid&out_ready -> IDLE. New operands are accepted no earlier than the following cycle.
//  - Throughput: one operation per WIDTH/2+2 cycles with out_ready tied high.
//  - WIDTH=2: a single RUN cycle; the first slice is also the last.
//  - Result fields are undefined outside DONE; they are cleared only at reset and on accept.
// STRUCTURE
//  - Shared include cla_defs.vh: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), SLICE_W=2.
//  - Instances: one existing pgu_su; one new sub-module clu_2b (p[1:0], g[1:0], cin -> c0, c1),
//    pure combinational and unit-testable on its own.
//  - idx width = clog2(WIDTH/2), minimum 1. Operand shifting is not used; slices are selected by idx.
// TESTING  (WIDTH=8 unless noted; check latency of 4 edges in every case)
//  1. a=0x5A b=0x3C sub=0 -> sum=0x96 cout=0 ovf=1.
//  2. a=0xFF b=0x01 sub=0 -> sum=0x00 cout=1 ovf=0.
//  3. a=0x10 b=0x01 sub=1 -> sum=0x0F cout=1 ovf=0; a=0x80 b=0x01 sub=1 -> sum=0x7F cout=1 ovf=1.
//  4. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b.
//     -> sum/cout/ovf stable, in_ready=0, nothing accepted. Release -> IDLE next edge.
//  5. rst_n pulsed low after 2 RUN edges -> outputs zero, out_valid never rises.
//     After release: in_ready=1, and a fresh 0x01+0x01 gives sum=0x02.
//  6. WIDTH=2 build, back-to-back ops with out_ready=1: 2'b11+2'b01 then 2'b10-2'b11.
//     -> sum=00 cout=1 ovf=0, then sum=11 cout=0 ovf=0, each 1 edge latency.

Source files
------------

// File: rtl/cla_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial carry-lookahead adder.
package cla_serial_adder_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Slice index width: enough to count WIDTH/2 slices, never narrower than 1 bit.
  function automatic int idx_w(input int width);
    return (width / SLICE_W > 1) ? $clog2(width / SLICE_W) : 1;
  endfunction

endpackage

// File: rtl/cla_serial_adder_if.sv
// Operand source / result sink handshake bundle for cla_serial_adder.
interface cla_serial_adder_if #(parameter int WIDTH = 8) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/cla_serial_adder_clu_2b.sv
// 2-bit carry lookahead: carries out of bit 0 (c0) and bit 1 (c1) from p/g and carry-in.
module clu_2b
  import cla_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] i_p,
  input  logic [SLICE_W-1:0] i_g,
  input  logic               i_cin,
  output logic               o_c0,
  output logic               o_c1
);

  assign o_c0 = i_g[0] | (i_p[0] & i_cin);
  assign o_c1 = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);

endmodule

// File: rtl/cla_serial_adder_pgu_su.sv
// 2-bit propagate/generate unit with sum; carries into each bit are supplied externally.
module pgu_su
  import cla_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  input  logic               i_c0,
  output logic [SLICE_W-1:0] o_p,
  output logic [SLICE_W-1:0] o_g,
  output logic [SLICE_W-1:0] o_sum
);

  assign o_p   = i_a ^ i_b;
  assign o_g   = i_a & i_b;
  assign o_sum = o_p ^ {i_c0, i_cin};

endmodule

// File: rtl/cla_serial_adder.sv
// Digit-serial add/subtract: walks WIDTH-bit operands through one 2-bit CLA slice, LSB first.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one 2-bit slice per cycle, selected by r_idx
// DONE  | result held until the sink takes it
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  cla_serial_adder_if.slave  bus
);

  localparam int NSL = WIDTH / SLICE_W;
  localparam int IW  = idx_w(WIDTH);

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
    $error("cla_serial_adder: WIDTH must be even and >= 2");
  end

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [NSL-1:0][SLICE_W-1:0]    r_a;
  logic [NSL-1:0][SLICE_W-1:0]    r_b;
  logic [NSL-1:0][SLICE_W-1:0]    r_sum;
  logic [NSL-1:0][SLICE_W-1:0]    w_sum_nxt;
  logic [IW-1:0]                  r_idx;
  logic                           r_carry;
  logic                           r_cout;
  logic                           r_ovf;
  logic [SLICE_W-1:0]             w_a_sl;
  logic [SLICE_W-1:0]             w_b_sl;
  logic [SLICE_W-1:0]             w_p;
  logic [SLICE_W-1:0]             w_g;
  logic [SLICE_W-1:0]             w_sout;
  logic                           w_c0;
  logic                           w_c1;
  logic                           w_last;
  logic                           w_accept;
  logic                           w_in_ready;
  logic                           w_out_valid;
  logic                           w_busy;

  // A single-slice build has nothing to select, so the indexed path is only elaborated when NSL > 1.
  if (NSL == 1) begin : g_single
    assign w_a_sl    = r_a[0];
    assign w_b_sl    = r_b[0];
    assign w_sum_nxt = w_sout;
  end else begin : g_multi
    assign w_a_sl = r_a[r_idx];
    assign w_b_sl = r_b[r_idx];
    always_comb begin
      w_sum_nxt        = r_sum;
      w_sum_nxt[r_idx] = w_sout;
    end
  end

  pgu_su u_pgu_su (
    .i_a   (w_a_sl),
    .i_b   (w_b_sl),
    .i_cin (r_carry),
    .i_c0  (w_c0),
    .o_p   (w_p),
    .o_g   (w_g),
    .o_sum (w_sout)
  );

  clu_2b u_clu_2b (
    .i_p   (w_p),
    .i_g   (w_g),
    .i_cin (r_carry),
    .o_c0  (w_c0),
    .o_c1  (w_c1)
  );

  assign w_last   = (r_idx == IW'(NSL - 1));
  assign w_accept = (r_state == ST_IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)        w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = 1'b1;
      ST_RUN:  w_busy     = 1'b1;
      ST_DONE: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: w_in_ready = 1'b0;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B once at accept and seed the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b ^ {WIDTH{bus.sub}};
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= bus.sub;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_sum   <= w_sum_nxt;
      r_carry <= w_c1;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c1;
        r_ovf  <= w_c0 ^ w_c1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Bench for cla_serial_adder: WIDTH=8 and WIDTH=2 instances against an arithmetic reference model.
module tb_cla_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_serial_adder_if #(.WIDTH(8)) if8 ();
  cla_serial_adder_if #(.WIDTH(2)) if2 ();

  cla_serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  cla_serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void model(input int w, input int av, input int bv, input bit s,
                                output int es, output bit ec, output bit eo);
    int mask, half, ua, ub, r, sa, sb, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    ua   = av & mask;
    ub   = bv & mask;
    r    = s ? (ua - ub + (1 << w)) : (ua + ub);
    sa   = (ua >= half) ? ua - (1 << w) : ua;
    sb   = (ub >= half) ? ub - (1 << w) : ub;
    sr   = s ? (sa - sb) : (sa + sb);
    es   = r & mask;
    ec   = ((r >> w) & 1) != 0;
    eo   = (sr < -half) || (sr > half - 1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  bit pend [2];
  int acc  [2];
  int m_sum[2];
  bit m_c  [2];
  bit m_o  [2];

  always @(negedge clk) begin
    int w, ov, ir, bs, iv, orr, s, c, o, ia, ib, isb, exp_ov;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        w = 8; ov = if8.out_valid; ir = if8.in_ready; bs = if8.busy; iv = if8.in_valid;
        orr = if8.out_ready; s = if8.sum; c = if8.cout; o = if8.ovf;
        ia = if8.a; ib = if8.b; isb = if8.sub;
      end else begin
        w = 2; ov = if2.out_valid; ir = if2.in_ready; bs = if2.busy; iv = if2.in_valid;
        orr = if2.out_ready; s = if2.sum; c = if2.cout; o = if2.ovf;
        ia = if2.a; ib = if2.b; isb = if2.sub;
      end
      if (!rst_n) begin
        pend[d] = 1'b0;
      end else begin
        exp_ov = (pend[d] && (cyc >= acc[d] + 1 + w / 2)) ? 1 : 0;
        check($sformatf("in_ready_w%0d", w), ir, pend[d] ? 0 : 1);
        check($sformatf("busy_w%0d", w), bs, pend[d] ? 1 : 0);
        check($sformatf("out_valid_w%0d", w), ov, exp_ov);
        if (ov != 0 && pend[d]) begin
          check($sformatf("sum_w%0d", w), s, m_sum[d]);
          check($sformatf("cout_w%0d", w), c, int'(m_c[d]));
          check($sformatf("ovf_w%0d", w), o, int'(m_o[d]));
        end
        if (pend[d] && ov != 0 && orr != 0) begin
          pend[d] = 1'b0;
        end else if (!pend[d] && iv != 0 && ir != 0) begin
          model(w, ia, ib, isb != 0, m_sum[d], m_c[d], m_o[d]);
          pend[d] = 1'b1;
          acc[d]  = cyc;
        end
      end
    end
  end

  task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                     input logic [7:0] es, input logic ec, input logic eo, input int hold);
    int n;
    @(posedge clk); #1;
    if8.in_valid  = 1'b1;
    if8.a         = ta;
    if8.b         = tbv;
    if8.sub       = ts;
    if8.out_ready = (hold == 0);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    n = 0;
    while (!if8.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency8", n, 4);
    check("lit_sum8", if8.sum, es);
    check("lit_cout8", if8.cout, ec);
    check("lit_ovf8", if8.ovf, eo);
    for (int i = 0; i < hold; i++) begin
      if8.in_valid = 1'($urandom_range(0, 1));
      if8.a        = 8'($urandom);
      if8.b        = 8'($urandom);
      @(posedge clk); #1;
      check("hold_sum", if8.sum, es);
      check("hold_cout", if8.cout, ec);
      check("hold_ovf", if8.ovf, eo);
      check("hold_in_ready", if8.in_ready, 0);
    end
    if (hold > 0) begin
      if8.in_valid  = 1'b0;
      if8.out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_idle", if8.in_ready, 1);
      check("release_valid", if8.out_valid, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.sub = 1'b0; if8.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.sub = 1'b0; if2.out_ready = 1'b1;

    @(negedge clk);
    check("rst_sum", if8.sum, 0);
    check("rst_cout", if8.cout, 0);
    check("rst_ovf", if8.ovf, 0);
    check("rst_valid", if8.out_valid, 0);
    check("rst_busy", if8.busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    op8(8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, 0);
    op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    op8(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
    op8(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 0);
    op8(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 5);

    // Abort after two RUN edges.
    @(posedge clk); #1;
    if8.in_valid = 1'b1; if8.a = 8'h33; if8.b = 8'h11; if8.sub = 1'b0;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_sum", if8.sum, 0);
    check("abort_cout", if8.cout, 0);
    check("abort_valid", if8.out_valid, 0);
    check("abort_busy", if8.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_abort_ready", if8.in_ready, 1);
    op8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

    // WIDTH=2 back-to-back with in_valid held high.
    @(posedge clk); #1;
    if2.in_valid = 1'b1; if2.a = 2'b11; if2.b = 2'b01; if2.sub = 1'b0;
    @(posedge clk); #1;
    if2.a = 2'b10; if2.b = 2'b11; if2.sub = 1'b1;
    n = 0;
    while (!if2.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency2a", n, 1);
    check("lit_sum2a", if2.sum, 0);
    check("lit_cout2a", if2.cout, 1);
    check("lit_ovf2a", if2.ovf, 0);
    @(posedge clk); #1;
    check("gap2_ready", if2.in_ready, 1);
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    n = 0;
    while (!if2.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency2b", n, 1);
    check("lit_sum2b", if2.sum, 3);
    check("lit_cout2b", if2.cout, 0);
    check("lit_ovf2b", if2.ovf, 0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
